// File: rtl/resp_serializer.sv
// -----------------------------------------------------------------------------
// resp_serializer
//   Pops one response packet at a time from resp_fifo and streams it to the
//   UART transmitter as a 9-byte frame, MSB-first:
//     SOF, cmd, addr[15:8], addr[7:0], data[31:24], data[23:16], data[15:8],
//     data[7:0], CHK
//   CHK is the XOR of bytes 1..7; SOF is not included in it.
//
//   fifo_data carries the fields of cmd_packet_t used here, packed as
//   {cmd[7:0], addr[15:0], data[31:0]} (56 bits).
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-low
//   fifo_valid   resp_fifo non-empty
//   fifo_data    packet at the FIFO head {cmd, addr, data}
//   fifo_rd_en   pop strobe to resp_fifo, one cycle per frame
//   tx_data      byte presented to UART TX (registered)
//   tx_valid     tx_data valid (registered)
//   tx_ready     UART TX accepts a byte when tx_valid && tx_ready
//   busy         frame in progress
//   frame_done   one-cycle pulse in the cycle the CHK byte is accepted
//   frame_count  frames completed since reset, wraps at 16'hFFFF
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a packet; loads the FIFO head and pops it
// SEND  | presenting byte idx; advances on each tx handshake
// -----------------------------------------------------------------------------
module resp_serializer #(
  parameter logic [7:0] SOF_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_valid,
  input  logic [55:0] fifo_data,
  output logic        fifo_rd_en,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  localparam int        FRAME_LEN = 9;
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);
  localparam logic [3:0] CHK_PREV = 4'(FRAME_LEN - 2);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  chk_q, chk_d;
  logic [55:0] pkt_q, pkt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic [15:0] count_q, count_d;
  logic        rd_en_c;
  logic        done_c;

  // Byte of the frame at position idx, for the positions that come straight
  // from the packet. Position 8 (CHK) is handled by the caller.
  function automatic logic [7:0] frame_byte(input logic [55:0] pkt,
                                            input logic [3:0]  idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = SOF_BYTE;
      4'd1:    b = pkt[55:48];
      4'd2:    b = pkt[47:40];
      4'd3:    b = pkt[39:32];
      4'd4:    b = pkt[31:24];
      4'd5:    b = pkt[23:16];
      4'd6:    b = pkt[15:8];
      4'd7:    b = pkt[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    chk_d      = chk_q;
    pkt_d      = pkt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    count_d    = count_q;
    rd_en_c    = 1'b0;
    done_c     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
        if (fifo_valid) begin
          pkt_d      = fifo_data;
          idx_d      = 4'd0;
          chk_d      = 8'h00;
          rd_en_c    = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = SOF_BYTE;
          state_d    = SEND;
        end
      end

      SEND: begin
        if (idx_q > LAST_IDX) begin
          // Corrupted index: abandon the frame rather than emit garbage.
          state_d    = IDLE;
          idx_d      = 4'd0;
          chk_d      = 8'h00;
          tx_valid_d = 1'b0;
          tx_data_d  = 8'h00;
        end else if (tx_valid_q && tx_ready) begin
          idx_d = idx_q + 4'd1;
          if (idx_q != 4'd0) begin
            chk_d = chk_q ^ tx_data_q;
          end
          if (idx_q == LAST_IDX) begin
            state_d    = IDLE;
            idx_d      = 4'd0;
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
            done_c     = 1'b1;
            count_d    = count_q + 16'd1;
          end else if (idx_q == CHK_PREV) begin
            // The last data byte is being accepted now, so the running
            // checksum including it is exactly the CHK byte to send next.
            tx_data_d = chk_d;
          end else begin
            tx_data_d = frame_byte(pkt_q, idx_q + 4'd1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q      <= 4'd0;
      chk_q      <= 8'h00;
      pkt_q      <= 56'h0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      count_q    <= 16'h0000;
    end else begin
      idx_q      <= idx_d;
      chk_q      <= chk_d;
      pkt_q      <= pkt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      count_q    <= count_d;
    end
  end

  // The pop strobe is combinational from fifo_valid, so it is also gated by
  // rst to keep it low while reset is held with a non-empty FIFO.
  assign fifo_rd_en  = rd_en_c & rst;
  assign frame_done  = done_c;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = (state_q != IDLE);
  assign frame_count = count_q;

endmodule

// File: tb/tb_resp_serializer.sv
module tb_resp_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_valid = 1'b0;
  logic [55:0] fifo_data = '0;
  logic        fifo_rd_en;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;

  resp_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_valid (fifo_valid),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Expected frames {SOF, cmd, addr, data, CHK}; the packet is bits [63:8].
  // 01^00^10^DE^AD^BE^EF = 33
  localparam logic [71:0] F0 = 72'hA5_01_0010_DEADBEEF_33;
  // 02^12^34 = 24
  localparam logic [71:0] F1 = 72'hA5_02_1234_00000000_24;
  // FF^01^02^03^04 = FB
  localparam logic [71:0] F2 = 72'hA5_FF_0000_01020304_FB;
  // 80^80^01^80 = 81
  localparam logic [71:0] F3 = 72'hA5_80_8001_80000000_81;

  // FIFO model: main thread owns wr_ptr, the FIFO process owns rd_ptr.
  logic [55:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cyc    = 0;
  logic pend = 1'b0;

  // Monitor-owned observations.
  logic [7:0] rx[$];
  int pop_cyc[$];
  int pop_cnt = 0;
  int fd_cnt  = 0;
  int act_cnt = 0;

  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (pend && rd_ptr != wr_ptr) rd_ptr++;
    fifo_valid = (rd_ptr != wr_ptr);
    fifo_data  = fifo_valid ? mem[rd_ptr % 16] : '0;
    @(negedge clk);
    #3;
    pend = fifo_rd_en;
  end

  always begin
    @(negedge clk);
    #2;
    if (tx_valid && tx_ready) rx.push_back(tx_data);
    if (fifo_rd_en) begin
      pop_cnt++;
      pop_cyc.push_back(cyc);
    end
    if (frame_done) fd_cnt++;
    if (fifo_rd_en || tx_valid || busy) act_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [55:0] p);
    mem[wr_ptr % 16] = p;
    wr_ptr++;
  endtask

  task automatic wait_fd(input int target, input int budget);
    int n = 0;
    while (fd_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val("frame_done_wait", 32'(fd_cnt >= target), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input string name, input int base,
                             input logic [71:0] exp);
    logic [7:0] e;
    check_val({name, "_len_min"}, 32'(rx.size() >= base + 9), 32'd1);
    for (int i = 0; i < 9; i++) begin
      e = exp[8*(8-i) +: 8];
      check_val($sformatf("%s_byte%0d", name, i), 32'(rx[base+i]), 32'(e));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, p0, d0, a0, pc, n, held;
    logic stall_done;

    rst      = 1'b0;
    tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_tx_valid",    32'(tx_valid),    32'd0);
    check_val("rst_tx_data",     32'(tx_data),     32'd0);
    check_val("rst_busy",        32'(busy),        32'd0);
    check_val("rst_rd_en",       32'(fifo_rd_en),  32'd0);
    check_val("rst_frame_done",  32'(frame_done),  32'd0);
    check_val("rst_frame_count", 32'(frame_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Empty FIFO: nothing moves.
    a0 = act_cnt;
    repeat (100) @(negedge clk);
    check_val("empty_activity", 32'(act_cnt - a0), 32'd0);

    // Single packet, tx_ready held high.
    tx_ready = 1'b1;
    base = rx.size(); p0 = pop_cnt; d0 = fd_cnt;
    push(F0[63:8]);
    wait_fd(d0 + 1, 40);
    check_val("single_nbytes", 32'(rx.size() - base), 32'd9);
    check_frame("single", base, F0);
    check_val("single_pops",  32'(pop_cnt - p0), 32'd1);
    check_val("single_done",  32'(fd_cnt - d0),  32'd1);
    check_val("single_count", 32'(frame_count),  32'd1);

    // Backpressure: stall 5 cycles while byte 3 (8'h10) is presented.
    base = rx.size(); p0 = pop_cnt; d0 = fd_cnt;
    held = 0; n = 0; stall_done = 1'b0;
    push(F0[63:8]);
    while (!stall_done && n < 40) begin
      @(negedge clk);
      n++;
      if (tx_valid && (rx.size() - base == 3)) begin
        tx_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (tx_valid && tx_data == 8'h10) held++;
        end
        tx_ready   = 1'b1;
        stall_done = 1'b1;
      end
    end
    check_val("bp_stall_reached", 32'(stall_done), 32'd1);
    wait_fd(d0 + 1, 40);
    check_val("bp_held_cycles", 32'(held), 32'd5);
    check_val("bp_nbytes", 32'(rx.size() - base), 32'd9);
    check_frame("bp", base, F0);
    check_val("bp_pops",  32'(pop_cnt - p0), 32'd1);
    check_val("bp_count", 32'(frame_count),  32'd2);

    // Back-to-back: three queued packets.
    base = rx.size(); p0 = pop_cnt; d0 = fd_cnt; pc = pop_cyc.size();
    push(F1[63:8]);
    push(F2[63:8]);
    push(F3[63:8]);
    wait_fd(d0 + 3, 80);
    check_val("b2b_nbytes", 32'(rx.size() - base), 32'd27);
    check_frame("b2b_f1", base,      F1);
    check_frame("b2b_f2", base + 9,  F2);
    check_frame("b2b_f3", base + 18, F3);
    check_val("b2b_pops", 32'(pop_cnt - p0), 32'd3);
    check_val("b2b_gap1", 32'(pop_cyc[pc+1] - pop_cyc[pc]),   32'd10);
    check_val("b2b_gap2", 32'(pop_cyc[pc+2] - pop_cyc[pc+1]), 32'd10);
    check_val("b2b_done",  32'(fd_cnt - d0),  32'd3);
    check_val("b2b_count", 32'(frame_count),  32'd5);

    // frame_count wrap.
    force dut.count_q = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    release dut.count_q;
    @(negedge clk);
    check_val("wrap_preload", 32'(frame_count), 32'h0000FFFF);
    base = rx.size(); d0 = fd_cnt;
    push(F0[63:8]);
    wait_fd(d0 + 1, 40);
    check_val("wrap_count", 32'(frame_count), 32'd0);
    check_val("wrap_done",  32'(fd_cnt - d0), 32'd1);
    check_frame("wrap", base, F0);

    // Reset mid-frame with a further packet still waiting in the FIFO.
    base = rx.size(); n = 0;
    push(F1[63:8]);
    push(F2[63:8]);
    while ((rx.size() - base) < 4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val("mid_rst_reached", 32'(rx.size() - base >= 4), 32'd1);
    #4;
    rst = 1'b0;
    #1;
    check_val("mid_rst_tx_valid",    32'(tx_valid),    32'd0);
    check_val("mid_rst_tx_data",     32'(tx_data),     32'd0);
    check_val("mid_rst_busy",        32'(busy),        32'd0);
    check_val("mid_rst_rd_en",       32'(fifo_rd_en),  32'd0);
    check_val("mid_rst_frame_done",  32'(frame_done),  32'd0);
    check_val("mid_rst_frame_count", 32'(frame_count), 32'd0);
    wr_ptr = rd_ptr;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    a0 = act_cnt;
    repeat (5) @(negedge clk);
    check_val("post_rst_idle", 32'(act_cnt - a0), 32'd0);

    // Recovery after reset.
    base = rx.size(); d0 = fd_cnt;
    push(F3[63:8]);
    wait_fd(d0 + 1, 40);
    check_val("recover_nbytes", 32'(rx.size() - base), 32'd9);
    check_frame("recover", base, F3);
    check_val("recover_count", 32'(frame_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
